uart_cmd_parser: RTL and testbench

//  Framed command decoder between the tool-side UART receiver/transmitter and the SoC controller.

---
 rtl/uart_cmd_parser_pkg.sv | 20 ++
 rtl/uart_reply_slot.sv | 54 +++++
 rtl/uart_cmd_parser.sv | 125 ++++++++++++
 tb/tb_uart_cmd_parser.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command parser: framing constants, reply defaults and FSM states.
package uart_cmd_parser_pkg;

  localparam int unsigned ARG_BIT   = 6;
  localparam int unsigned ARG_BYTES = 4;

  localparam logic [7:0] ACK_DEFAULT = 8'h06;
  localparam logic [7:0] NAK_DEFAULT = 8'h15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARG,
    ST_ISSUE
  } state_e;

  function automatic logic has_arg(input logic [7:0] op);
    return op[ARG_BIT];
  endfunction

endpackage

// File: rtl/uart_reply_slot.sv
// One-entry ACK/NAK reply buffer feeding the UART transmitter; NAK dominates when replies collide.
module uart_reply_slot
  import uart_cmd_parser_pkg::*;
#(
  parameter logic [7:0] ACK_BYTE = ACK_DEFAULT,
  parameter logic [7:0] NAK_BYTE = NAK_DEFAULT
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       push_ack,
  input  logic       push_nak,
  input  logic       tx_busy,
  output logic       tx_en,
  output logic [7:0] tx_data
);

  logic       full_q, full_d;
  logic       nak_q, nak_d;
  logic       tx_en_q, tx_en_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       pop;

  always_comb begin
    pop       = full_q & ~tx_busy;
    tx_en_d   = pop;
    tx_data_d = tx_data_q;
    full_d    = full_q & ~pop;
    nak_d     = nak_q;
    if (pop) tx_data_d = nak_q ? NAK_BYTE : ACK_BYTE;
    // A reply arriving in the cycle the slot drains starts a fresh entry.
    if (push_ack | push_nak) begin
      nak_d  = full_d ? (nak_q | push_nak) : push_nak;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      full_q    <= 1'b0;
      nak_q     <= 1'b0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      full_q    <= full_d;
      nak_q     <= nak_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign tx_en   = tx_en_q;
  assign tx_data = tx_data_q;

endmodule

// File: rtl/uart_cmd_parser.sv
// Framed UART command decoder: opcode plus optional 32-bit LE argument, valid/ready to the
// controller, ACK/NAK reply, inter-byte timeout and overrun detection.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 27000000,
  parameter int unsigned TIMEOUT_CYCLES = CLK_HZ / 100,
  parameter logic [7:0]  ACK_BYTE       = ACK_DEFAULT,
  parameter logic [7:0]  NAK_BYTE       = NAK_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_break,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_opcode,
  output logic [31:0] cmd_arg,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic [7:0]  err_count
);

  localparam int unsigned    TW            = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TIMEOUT_LIMIT = TW'(TIMEOUT_CYCLES);

  state_e        state_q, state_d;
  logic [7:0]    opcode_q, opcode_d;
  logic [31:0]   arg_q, arg_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    err_count_q, err_count_d;
  logic          push_ack, push_nak, decode;

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    arg_d       = arg_q;
    byte_idx_d  = byte_idx_q;
    timer_d     = timer_q;
    err_count_d = err_count_q;
    push_ack    = 1'b0;
    push_nak    = 1'b0;
    decode      = 1'b0;

    case (state_q)
      ST_IDLE: decode = rx_valid;
      ST_ARG: begin
        timer_d = timer_q + TW'(1);
        if (rx_break) begin
          state_d = ST_IDLE;
        end else if (rx_valid) begin
          arg_d[8*byte_idx_q +: 8] = rx_data;
          timer_d    = '0;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'(ARG_BYTES - 1)) state_d = ST_ISSUE;
        end else if (timer_q == TIMEOUT_LIMIT) begin
          push_nak = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          push_ack = 1'b1;
          state_d  = ST_IDLE;
          decode   = rx_valid;
        end else if (rx_valid) begin
          push_nak = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A byte accepted alongside the handshake starts the next frame directly.
    if (decode) begin
      opcode_d   = rx_data;
      arg_d      = '0;
      byte_idx_d = '0;
      timer_d    = '0;
      state_d    = has_arg(rx_data) ? ST_ARG : ST_ISSUE;
    end

    if (state_d != ST_ARG) timer_d = '0;
    if (push_nak && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      opcode_q    <= '0;
      arg_q       <= '0;
      byte_idx_q  <= '0;
      timer_q     <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      arg_q       <= arg_d;
      byte_idx_q  <= byte_idx_d;
      timer_q     <= timer_d;
      err_count_q <= err_count_d;
    end
  end

  assign cmd_valid  = (state_q == ST_ISSUE);
  assign cmd_opcode = opcode_q;
  assign cmd_arg    = arg_q;
  assign err_count  = err_count_q;

  uart_reply_slot #(
    .ACK_BYTE(ACK_BYTE),
    .NAK_BYTE(NAK_BYTE)
  ) u_reply_slot (
    .clk     (clk),
    .resetn  (resetn),
    .push_ack(push_ack),
    .push_nak(push_nak),
    .tx_busy (tx_busy),
    .tx_en   (tx_en),
    .tx_data (tx_data)
  );

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: stimulus queues expected commands/replies, a monitor compares.
module tb_uart_cmd_parser;

  localparam int unsigned TO = 20;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_break = 1'b0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [7:0]  cmd_opcode;
  logic [31:0] cmd_arg;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic [7:0]  err_count;

  int vectors = 0;
  int miscompares = 0;

  logic [39:0] cmd_q[$];
  logic [7:0]  tx_q[$];

  uart_cmd_parser #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_break  (rx_break),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_opcode(cmd_opcode),
    .cmd_arg   (cmd_arg),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares handshakes and reply strobes against the queues.
  logic        prev_pending = 1'b0;
  logic [39:0] prev_cmd = '0;
  always @(negedge clk) begin
    if (!resetn) begin
      prev_pending = 1'b0;
    end else begin
      if (prev_pending) begin
        chk("cmd_held_valid", {39'd0, cmd_valid}, 40'd1);
        chk("cmd_held_stable", {cmd_opcode, cmd_arg}, prev_cmd);
      end
      if (cmd_valid && cmd_ready) begin
        if (cmd_q.size() == 0) chk("unexpected_cmd", {cmd_opcode, cmd_arg}, 40'hxx_xxxx_xxxx);
        else chk("cmd", {cmd_opcode, cmd_arg}, cmd_q.pop_front());
      end
      if (tx_en) begin
        if (tx_q.size() == 0) chk("unexpected_tx", {32'd0, tx_data}, 40'hxx);
        else chk("tx", {32'd0, tx_data}, {32'd0, tx_q.pop_front()});
      end
      prev_pending = cmd_valid && !cmd_ready;
      prev_cmd     = {cmd_opcode, cmd_arg};
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int limit);
    int n = 0;
    while ((cmd_q.size() != 0 || tx_q.size() != 0) && n < limit) begin
      tick(1);
      n++;
    end
    chk(name, {cmd_q.size() != 0, tx_q.size() != 0}, 40'd0);
    tick(2);
  endtask

  task automatic check_idle(input string name);
    chk({name, "_cmd_valid"}, {39'd0, cmd_valid}, 40'd0);
    chk({name, "_tx_en"}, {39'd0, tx_en}, 40'd0);
    chk({name, "_err_count"}, {32'd0, err_count}, 40'd0);
    chk({name, "_cmd"}, {cmd_opcode, cmd_arg}, 40'd0);
    chk({name, "_tx_data"}, {32'd0, tx_data}, 40'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset with rx activity
    tick(1);
    for (int i = 0; i < 4; i++) begin
      rx_valid = i[0];
      rx_data  = 8'h41;
      tick(1);
    end
    rx_valid = 1'b0;
    check_idle("in_reset");
    resetn = 1'b1;
    tick(3);
    check_idle("after_reset");

    // 2. single no-argument command with immediate ready
    cmd_ready = 1'b1;
    cmd_q.push_back({8'h02, 32'd0});
    tx_q.push_back(8'h06);
    send(8'h02);
    chk("latency_valid", {39'd0, cmd_valid}, 40'd1);
    drain("drain_t2", 20);

    // 3. argument frame held while ready is low
    cmd_ready = 1'b0;
    cmd_q.push_back({8'h40, 32'h1234_5678});
    tx_q.push_back(8'h06);
    send(8'h40); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    chk("arg_valid", {39'd0, cmd_valid}, 40'd1);
    tick(5);
    chk("arg_held", {cmd_opcode, cmd_arg}, {8'h40, 32'h1234_5678});
    cmd_ready = 1'b1;
    drain("drain_t3", 20);

    // 4. inter-byte timeout, break abort, then normal command
    tx_q.push_back(8'h15);
    send(8'h41); send(8'hAA);
    drain("drain_timeout", TO + 20);
    chk("err_after_timeout", {32'd0, err_count}, 40'd1);
    send(8'h43); send(8'h01);
    rx_break = 1'b1;
    tick(1);
    rx_break = 1'b0;
    tick(TO + 10);
    chk("err_after_break", {32'd0, err_count}, 40'd1);
    cmd_q.push_back({8'h03, 32'd0});
    tx_q.push_back(8'h06);
    send(8'h03);
    drain("drain_t4", 20);

    // 5. overrun while pending, then simultaneous ready + byte
    cmd_ready = 1'b0;
    cmd_q.push_back({8'h07, 32'd0});
    send(8'h07);
    tick(1);
    tx_q.push_back(8'h15);
    send(8'h05);
    chk("err_after_overrun", {32'd0, err_count}, 40'd2);
    chk("still_pending", {39'd0, cmd_valid}, 40'd1);
    tick(4);
    tx_q.push_back(8'h06);
    cmd_q.push_back({8'h01, 32'd0});
    cmd_ready = 1'b1;
    rx_valid  = 1'b1;
    rx_data   = 8'h01;
    tick(1);
    rx_valid  = 1'b0;
    cmd_ready = 1'b0;
    chk("next_frame", {31'd0, cmd_valid, cmd_opcode}, {31'd0, 1'b1, 8'h01});
    tick(4);
    tx_q.push_back(8'h06);
    cmd_ready = 1'b1;
    drain("drain_t5", 20);

    // 6. busy transmitter: NAK overwrites queued ACK
    tx_busy = 1'b1;
    cmd_q.push_back({8'h06, 32'd0});
    send(8'h06);
    tick(2);
    cmd_ready = 1'b0;
    cmd_q.push_back({8'h00, 32'd0});
    send(8'h00); send(8'h08);
    chk("err_after_overrun2", {32'd0, err_count}, 40'd3);
    tx_q.push_back(8'h15);
    tick(3);
    tx_busy = 1'b0;
    wait_tx_only();
    tx_q.push_back(8'h06);
    cmd_ready = 1'b1;
    drain("drain_t6", 20);

    // reset in the middle of an argument frame
    send(8'h42); send(8'h11); send(8'h22);
    resetn = 1'b0;
    tick(2);
    check_idle("mid_arg_reset");
    resetn = 1'b1;
    tick(TO + 20);
    check_idle("post_reset_quiet");
    cmd_q.push_back({8'h01, 32'd0});
    tx_q.push_back(8'h06);
    send(8'h01);
    drain("drain_final", 20);

    chk("cmd_queue_empty", 40'(cmd_q.size()), 40'd0);
    chk("tx_queue_empty", 40'(tx_q.size()), 40'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  task automatic wait_tx_only();
    int n = 0;
    while (tx_q.size() != 0 && n < 20) begin
      tick(1);
      n++;
    end
    chk("drain_busy_nak", 40'(tx_q.size()), 40'd0);
    tick(2);
  endtask

endmodule
